// File: rtl/calc_pkg.sv
// calc_pkg
//   Shared types and constants for the calculator entry path.
//   - op_t      : keypad operator codes as delivered by the scanner
//   - state_t   : entry controller FSM states
//   - neg_t     : result of a saturating-aware 16-bit negation
//   - MAXMAG_DEFAULT, DEC_BASE : entry limit and decimal base
package calc_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_DIV  = 3'd4,
    OP_NEG  = 3'd5,
    OP_CLR  = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'd0,
    ST_ENTER_B = 2'd1,
    ST_EXEC    = 2'd2,
    ST_SHOW    = 2'd3
  } state_t;

  typedef struct packed {
    logic               ovf;
    logic signed [15:0] val;
  } neg_t;

  localparam int MAXMAG_DEFAULT = 32767;
  localparam int DEC_BASE       = 10;

  // ADD..DIV are the binary operators that go to the ALU.
  function automatic logic is_arith(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // -32768 has no positive counterpart: keep the value and flag it.
  function automatic neg_t negate16(input logic signed [15:0] v);
    neg_t r;
    if (v == 16'sh8000) begin
      r.ovf = 1'b1;
      r.val = v;
    end else begin
      r.ovf = 1'b0;
      r.val = -v;
    end
    return r;
  endfunction

endpackage

// File: rtl/entry_control_if.sv
// entry_control_if
//   Bundles the keypad handshake and the ALU/display bus of the entry
//   controller.
//   Keypad side : KeyRdy, Number, Operator, EqualSign -> ; <- KeyRd
//   ALU side    : OperandA, OperandB, OpCode, Start -> ; <- Done, Result
//   Display     : DispValue, Err
//   modport slave  : the entry controller
//   modport master : the surrounding system (scanner, ALU, display)
interface entry_control_if;
  logic               KeyRdy;
  logic [3:0]         Number;
  logic [2:0]         Operator;
  logic               EqualSign;
  logic               KeyRd;
  logic signed [15:0] OperandA;
  logic signed [15:0] OperandB;
  logic [2:0]         OpCode;
  logic               Start;
  logic               Done;
  logic signed [15:0] Result;
  logic signed [15:0] DispValue;
  logic               Err;

  modport slave (
    input  KeyRdy, Number, Operator, EqualSign, Done, Result,
    output KeyRd, OperandA, OperandB, OpCode, Start, DispValue, Err
  );

  modport master (
    output KeyRdy, Number, Operator, EqualSign, Done, Result,
    input  KeyRd, OperandA, OperandB, OpCode, Start, DispValue, Err
  );
endinterface

// File: rtl/operand_accum.sv
// operand_accum
//   Combinational decimal digit append: sum = sign(value) * (|value|*10 + digit).
//   Ports:
//     value : current signed operand
//     digit : decimal digit 0..9
//     sum   : appended operand (valid when ovf = 0)
//     ovf   : new magnitude would exceed MAXMAG
module operand_accum
  import calc_pkg::*;
#(
  parameter int MAXMAG = MAXMAG_DEFAULT
) (
  input  logic signed [15:0] value,
  input  logic [3:0]         digit,
  output logic signed [15:0] sum,
  output logic               ovf
);

  logic signed [31:0] wide;
  logic signed [31:0] mag;
  logic signed [31:0] grown;

  always_comb begin
    // Work at 32 bits so |-32768| and the x10 step cannot wrap.
    wide  = 32'(value);
    mag   = (wide < 0) ? -wide : wide;
    grown = mag * DEC_BASE + $signed({28'd0, digit});
    ovf   = (grown > MAXMAG);
    sum   = (wide < 0) ? 16'(-grown) : 16'(grown);
  end

endmodule

// File: rtl/entry_control.sv
// entry_control
//   Consumes decoded keypad keys through the KeyRdy/KeyRd handshake, builds
//   two signed 16-bit operands and an opcode, launches the ALU with a
//   one-cycle Start pulse and drives the display value.
//   Ports:
//     Clock : system clock, rising edge
//     Reset : synchronous, active-low
//     bus   : entry_control_if.slave (keypad handshake, ALU bus, display)
module entry_control
  import calc_pkg::*;
#(
  parameter int MAXMAG = MAXMAG_DEFAULT
) (
  input logic            Clock,
  input logic            Reset,
  entry_control_if.slave bus
);

  state_t             state_reg, state_next;
  logic signed [15:0] a_reg, a_next;
  logic signed [15:0] b_reg, b_next;
  logic signed [15:0] res_reg, res_next;
  logic signed [15:0] disp_reg, disp_next;
  op_t                opcode_reg, opcode_next;
  logic               err_reg, err_next;
  logic               keyrd_reg, keyrd_next;
  logic               start_reg, start_next;
  logic               armed_reg, armed_next;
  logic               bdig_reg, bdig_next;

  // Key decode, priority: equals, then operator, then digit.
  op_t  key_op;
  logic key_eq;
  logic is_digit;
  logic accept;

  assign key_op   = op_t'(bus.Operator);
  assign key_eq   = bus.EqualSign;
  assign is_digit = !key_eq && (key_op == OP_NONE) && (bus.Number <= 4'd9);
  assign accept   = bus.KeyRdy && armed_reg && (state_reg != ST_EXEC);

  // Single digit accumulator shared by A and B. From SHOW a digit starts a
  // fresh A, so the accumulator sees zero there.
  logic signed [15:0] acc_in;
  logic signed [15:0] acc_sum;
  logic               acc_ovf;

  always_comb begin
    case (state_reg)
      ST_ENTER_B: acc_in = b_reg;
      ST_SHOW:    acc_in = '0;
      default:    acc_in = a_reg;
    endcase
  end

  operand_accum #(.MAXMAG(MAXMAG)) u_accum (
    .value (acc_in),
    .digit (bus.Number),
    .sum   (acc_sum),
    .ovf   (acc_ovf)
  );

  // NEG operates on B in ENTER_B, on the result in SHOW, on A otherwise.
  logic signed [15:0] neg_in;
  neg_t               neg_res;

  always_comb begin
    case (state_reg)
      ST_ENTER_B: neg_in = b_reg;
      ST_SHOW:    neg_in = res_reg;
      default:    neg_in = a_reg;
    endcase
    neg_res = negate16(neg_in);
  end

  // State and datapath registers.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg  <= ST_ENTER_A;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      disp_reg   <= '0;
      opcode_reg <= OP_NONE;
      err_reg    <= 1'b0;
      keyrd_reg  <= 1'b0;
      start_reg  <= 1'b0;
      armed_reg  <= 1'b1;
      bdig_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      res_reg    <= res_next;
      disp_reg   <= disp_next;
      opcode_reg <= opcode_next;
      err_reg    <= err_next;
      keyrd_reg  <= keyrd_next;
      start_reg  <= start_next;
      armed_reg  <= armed_next;
      bdig_reg   <= bdig_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EXEC: begin
        if (bus.Done) state_next = ST_SHOW;
      end
      default: begin
        if (accept) begin
          if (key_eq) begin
            if (state_reg == ST_ENTER_B) state_next = ST_EXEC;
          end else if (key_op == OP_CLR) begin
            state_next = ST_ENTER_A;
          end else if (state_reg == ST_ENTER_A) begin
            if (is_arith(key_op)) state_next = ST_ENTER_B;
          end else if (state_reg == ST_SHOW) begin
            if (is_arith(key_op))                        state_next = ST_ENTER_B;
            else if ((key_op == OP_NEG) || is_digit)     state_next = ST_ENTER_A;
          end
        end
      end
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    a_next      = a_reg;
    b_next      = b_reg;
    res_next    = res_reg;
    opcode_next = opcode_reg;
    err_next    = err_reg;
    bdig_next   = bdig_reg;
    keyrd_next  = accept;
    start_next  = 1'b0;

    // Re-arm only after KeyRdy has been seen low, so a held key counts once.
    if (accept)           armed_next = 1'b0;
    else if (!bus.KeyRdy) armed_next = 1'b1;
    else                  armed_next = armed_reg;

    if (state_reg == ST_EXEC) begin
      if (bus.Done) res_next = bus.Result;
    end else if (accept) begin
      if (key_eq) begin
        if (state_reg == ST_ENTER_B) begin
          start_next = 1'b1;
          if (!bdig_reg) b_next = '0;
        end
      end else if (key_op == OP_CLR) begin
        a_next      = '0;
        b_next      = '0;
        opcode_next = OP_NONE;
        err_next    = 1'b0;
        bdig_next   = 1'b0;
      end else if (key_op == OP_NEG) begin
        err_next = err_reg | neg_res.ovf;
        if (state_reg == ST_ENTER_B) b_next = neg_res.val;
        else                         a_next = neg_res.val;
      end else if (is_arith(key_op)) begin
        case (state_reg)
          ST_ENTER_A: begin
            opcode_next = key_op;
            b_next      = '0;
            bdig_next   = 1'b0;
          end
          ST_ENTER_B: begin
            // The operator may be changed until B entry has begun.
            if (!bdig_reg) opcode_next = key_op;
          end
          ST_SHOW: begin
            a_next      = res_reg;
            opcode_next = key_op;
            b_next      = '0;
            bdig_next   = 1'b0;
          end
          default: ;
        endcase
      end else if (is_digit) begin
        err_next = err_reg | acc_ovf;
        case (state_reg)
          ST_ENTER_B: begin
            if (!acc_ovf) begin
              b_next    = acc_sum;
              bdig_next = 1'b1;
            end
          end
          ST_SHOW: begin
            b_next    = '0;
            bdig_next = 1'b0;
            a_next    = acc_ovf ? 16'sd0 : acc_sum;
          end
          default: begin
            if (!acc_ovf) a_next = acc_sum;
          end
        endcase
      end
    end

    // Display follows the operand being edited; frozen while the ALU runs.
    case (state_next)
      ST_ENTER_A: disp_next = a_next;
      ST_ENTER_B: disp_next = b_next;
      ST_SHOW:    disp_next = res_next;
      default:    disp_next = disp_reg;
    endcase
  end

  assign bus.KeyRd     = keyrd_reg;
  assign bus.OperandA  = a_reg;
  assign bus.OperandB  = b_reg;
  assign bus.OpCode    = opcode_reg;
  assign bus.Start     = start_reg;
  assign bus.DispValue = disp_reg;
  assign bus.Err       = err_reg;

endmodule

// File: tb/tb_entry_control.sv
// tb_entry_control
//   Directed test-plan sequences followed by randomized keys, checked
//   against a behavioural model of the entry rules.
module tb_entry_control;
  import calc_pkg::*;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  entry_control_if bus();

  entry_control #(.MAXMAG(MAXMAG_DEFAULT)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model of the visible calculator state.
  int     m_a, m_b, m_op, m_res, m_disp;
  bit     m_err, m_bdig;
  state_t m_state;

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_disp = 0;
    m_err = 0; m_bdig = 0; m_state = ST_ENTER_A;
  endtask

  // Digit entry: magnitude*10 + digit, refused beyond the limit.
  function automatic bit m_append(input int v, input int d, output int nv);
    int mag, n;
    mag = (v < 0) ? -v : v;
    n   = mag * 10 + d;
    if (n > MAXMAG_DEFAULT) begin
      nv = v;
      return 1'b1;
    end
    nv = (v < 0) ? -n : n;
    return 1'b0;
  endfunction

  function automatic int m_neg(input int v, inout bit err);
    if (v == -32768) begin
      err = 1'b1;
      return v;
    end
    return -v;
  endfunction

  task automatic model_key(input bit eq, input int op, input int num, output bit start);
    int nv;
    start = 0;
    if (eq) begin
      if (m_state == ST_ENTER_B) begin
        if (!m_bdig) m_b = 0;
        start   = 1;
        m_state = ST_EXEC;
      end
    end else if (op == 6) begin
      model_reset();
    end else if (op >= 1 && op <= 4) begin
      if (m_state == ST_ENTER_A) begin
        m_op = op; m_b = 0; m_bdig = 0; m_state = ST_ENTER_B;
      end else if (m_state == ST_ENTER_B) begin
        if (!m_bdig) m_op = op;
      end else if (m_state == ST_SHOW) begin
        m_a = m_res; m_op = op; m_b = 0; m_bdig = 0; m_state = ST_ENTER_B;
      end
    end else if (op == 5) begin
      if (m_state == ST_ENTER_A)      m_a = m_neg(m_a, m_err);
      else if (m_state == ST_ENTER_B) m_b = m_neg(m_b, m_err);
      else if (m_state == ST_SHOW) begin
        m_a = m_neg(m_res, m_err);
        m_state = ST_ENTER_A;
      end
    end else if (op == 0 && num <= 9) begin
      if (m_state == ST_ENTER_A) begin
        if (m_append(m_a, num, nv)) m_err = 1; else m_a = nv;
      end else if (m_state == ST_ENTER_B) begin
        if (m_append(m_b, num, nv)) m_err = 1;
        else begin m_b = nv; m_bdig = 1; end
      end else if (m_state == ST_SHOW) begin
        m_b = 0; m_bdig = 0; m_a = num; m_state = ST_ENTER_A;
      end
    end
    if (m_state == ST_ENTER_A)      m_disp = m_a;
    else if (m_state == ST_ENTER_B) m_disp = m_b;
    else if (m_state == ST_SHOW)    m_disp = m_res;
  endtask

  task automatic check_regs();
    chk("operand_a", bus.OperandA, m_a);
    chk("operand_b", bus.OperandB, m_b);
    chk("opcode", {29'd0, bus.OpCode}, m_op);
    chk("err", {31'd0, bus.Err}, int'(m_err));
    chk("disp", bus.DispValue, m_disp);
    chk("state", {30'd0, dut.state_reg}, int'(m_state));
  endtask

  // One complete key transaction: present, check the acknowledge cycle,
  // release, check the pulses have ended.
  task automatic press(input bit eq, input int op, input int num);
    bit exp_start;
    bus.KeyRdy = 1; bus.EqualSign = eq; bus.Operator = 3'(op); bus.Number = 4'(num);
    @(posedge Clock); #1;
    model_key(eq, op, num, exp_start);
    chk("keyrd", {31'd0, bus.KeyRd}, 1);
    chk("start", {31'd0, bus.Start}, int'(exp_start));
    check_regs();
    $display("[TB] key eq=%0d op=%0d num=%0d -> A=%0d B=%0d op=%0d disp=%0d err=%0d",
             eq, op, num, bus.OperandA, bus.OperandB, bus.OpCode, bus.DispValue, bus.Err);
    bus.KeyRdy = 0; bus.EqualSign = 0; bus.Operator = 0; bus.Number = 0;
    @(posedge Clock); #1;
    chk("keyrd_pulse", {31'd0, bus.KeyRd}, 0);
    chk("start_pulse", {31'd0, bus.Start}, 0);
  endtask

  // ALU completion after a few busy cycles.
  task automatic alu_done(input int r, input int busy);
    repeat (busy) begin
      @(posedge Clock); #1;
      chk("exec_hold", {30'd0, dut.state_reg}, int'(ST_EXEC));
      chk("exec_keyrd", {31'd0, bus.KeyRd}, 0);
    end
    bus.Done = 1; bus.Result = 16'(r);
    @(posedge Clock); #1;
    bus.Done = 0;
    m_res = r; m_disp = r; m_state = ST_SHOW;
    check_regs();
    $display("[TB] done result=%0d -> disp=%0d", r, bus.DispValue);
  endtask

  initial begin
    int pulses, r, sel;
    bit dummy;
    bus.KeyRdy = 0; bus.Number = 0; bus.Operator = 0; bus.EqualSign = 0;
    bus.Done = 0; bus.Result = 0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_keyrd", {31'd0, bus.KeyRd}, 0);
    chk("rst_start", {31'd0, bus.Start}, 0);
    check_regs();
    Reset = 1;
    @(posedge Clock); #1;

    // 1,2,ADD,3,= then Result 15.
    press(0, 0, 1); press(0, 0, 2); press(0, 1, 0); press(0, 0, 3);
    press(1, 0, 0);
    chk("tp1_a", bus.OperandA, 12);
    chk("tp1_b", bus.OperandB, 3);
    chk("tp1_op", {29'd0, bus.OpCode}, 1);
    alu_done(15, 2);
    chk("tp1_disp", bus.DispValue, 15);

    // Entry limit, then CLR.
    press(0, 6, 0);
    press(0, 0, 3); press(0, 0, 2); press(0, 0, 7); press(0, 0, 6); press(0, 0, 7);
    chk("tp2_a", bus.OperandA, 32767);
    press(0, 0, 8);
    chk("tp2_err", {31'd0, bus.Err}, 1);
    chk("tp2_a_keep", bus.OperandA, 32767);
    press(0, 6, 0);
    chk("tp2_clr_a", bus.OperandA, 0);
    chk("tp2_clr_err", {31'd0, bus.Err}, 0);

    // Done outside EXEC is ignored.
    bus.Done = 1; bus.Result = 16'(1234);
    @(posedge Clock); #1;
    bus.Done = 0;
    check_regs();

    // 5,NEG,MUL,SUB,4,=
    press(0, 0, 5); press(0, 5, 0); press(0, 3, 0); press(0, 2, 0); press(0, 0, 4);
    press(1, 0, 0);
    chk("tp3_a", bus.OperandA, -5);
    chk("tp3_b", bus.OperandB, 4);
    chk("tp3_op", {29'd0, bus.OpCode}, 2);
    // Result -32768 then NEG: value kept, Err set.
    alu_done(-32768, 1);
    press(0, 5, 0);
    chk("neg_min_a", bus.OperandA, -32768);
    chk("neg_min_err", {31'd0, bus.Err}, 1);
    press(0, 6, 0);

    // Held key: one acknowledge in 20 cycles.
    pulses = 0;
    bus.KeyRdy = 1; bus.Number = 4'd7;
    repeat (20) begin
      @(posedge Clock); #1;
      if (bus.KeyRd === 1'b1) pulses++;
    end
    model_key(0, 0, 7, dummy);
    chk("hold_pulses", pulses, 1);
    check_regs();
    bus.KeyRdy = 0; bus.Number = 0;
    @(posedge Clock); #1;
    press(0, 0, 7);
    chk("hold_second", bus.OperandA, 77);

    // Key pending during EXEC, accepted after Done.
    press(0, 6, 0); press(0, 0, 4); press(0, 1, 0); press(0, 0, 3); press(1, 0, 0);
    bus.KeyRdy = 1; bus.Operator = 3'd1;
    alu_done(7, 5);
    chk("exec_done_keyrd", {31'd0, bus.KeyRd}, 0);
    @(posedge Clock); #1;
    model_key(0, 1, 0, dummy);
    chk("exec_pend_keyrd", {31'd0, bus.KeyRd}, 1);
    chk("exec_pend_a", bus.OperandA, 7);
    chk("exec_pend_state", {30'd0, dut.state_reg}, int'(ST_ENTER_B));
    check_regs();
    bus.KeyRdy = 0; bus.Operator = 0;
    @(posedge Clock); #1;

    // Reset in ENTER_B with A=9.
    press(0, 6, 0); press(0, 0, 9); press(0, 4, 0);
    Reset = 0;
    @(posedge Clock); #1;
    model_reset();
    chk("rst2_keyrd", {31'd0, bus.KeyRd}, 0);
    chk("rst2_start", {31'd0, bus.Start}, 0);
    check_regs();
    Reset = 1;
    @(posedge Clock); #1;

    // Randomized keys and ALU results.
    for (int i = 0; i < 300; i++) begin
      if (m_state == ST_EXEC) begin
        r = int'($urandom_range(0, 65535)) - 32768;
        alu_done(r, int'($urandom_range(0, 3)));
      end else begin
        sel = int'($urandom_range(0, 99));
        if (sel < 10)      press(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        else if (sel < 30) press(0, int'($urandom_range(1, 7)), int'($urandom_range(0, 15)));
        else if (sel < 36) press(0, 0, int'($urandom_range(10, 15)));
        else               press(0, 0, int'($urandom_range(0, 9)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/entry_control.md
# entry_control

Consumer side of the keypad key handshake. It takes decoded keys (digit, operator, equals) from the keypad scanner through the `KeyRdy`/`KeyRd` handshake and assembles two signed 16-bit operands plus an opcode. It then launches the ALU with a one-cycle `Start` pulse and presents the current entry or result for display. It sits between the keypad scanner and the ALU/display path of the calculator.

## Interface
Parameters:
- `MAXMAG`, default 32767: largest operand magnitude accepted during digit entry.

Ports:
- `Clock`  in  1  system clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `KeyRdy`  in  1  scanner holds a key: `Number`/`Operator`/`EqualSign` are valid.
- `Number`  in  4  digit 0–9; values 10–15 are ignored (consumed, no effect).
- `Operator`  in  3  0 none, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 NEG, 6 CLR, 7 reserved (consumed, no effect).
- `EqualSign`  in  1  equals key.
- `KeyRd`  out  1  one-cycle acknowledge; the scanner drops `KeyRdy` afterwards.
- `OperandA`, `OperandB`  out  16  signed two's-complement operands to the ALU.
- `OpCode`  out  3  pending operator (ADD..DIV).
- `Start`  out  1  one-cycle ALU launch pulse.
- `Done`  in  1  one-cycle ALU completion pulse.
- `Result`  in  16  signed ALU result; valid while `Done`=1.
- `DispValue`  out  16  signed value to display.
- `Err`  out  1  sticky entry error.

## Operation
- Key class priority: `EqualSign` first, then `Operator`≠0, otherwise digit.
- FSM states: ENTER_A, ENTER_B, EXEC, SHOW. Reset state is ENTER_A.
- Reset values: all outputs 0. The accept guard is armed.
- Digit append: new magnitude = mag×10 + digit, sign preserved. If the new magnitude exceeds `MAXMAG`: the digit is dropped, `Err`=1, and the operand is unchanged.
- ENTER_A:
  - digit appends to A.
  - NEG negates A.
  - ADD..DIV latch `OpCode`, clear B, go to ENTER_B.
  - Equals is consumed with no effect.
- ENTER_B:
  - digit appends to B.
  - NEG negates B.
  - ADD..DIV with no B digit yet replace `OpCode`. Once a B digit has been entered, they are consumed with no effect.
  - Equals pulses `Start` and goes to EXEC. If no B digit was entered, B=0.
- EXEC:
  - No key is consumed; `KeyRd` stays 0 and any pending `KeyRdy` is left waiting.
  - On `Done`, latch `Result` into an internal result register and go to SHOW.
- SHOW:
  - digit clears B, sets A=digit, goes to ENTER_A.
  - ADD..DIV set A=result, latch `OpCode`, clear B, go to ENTER_B (chaining).
  - NEG sets A=−result, goes to ENTER_A.
  - Equals is consumed with no effect.
- CLR in any state except EXEC: A, B, `OpCode`, `Err` and `DispValue` go to 0; state goes to ENTER_A.
- Negating −32768 leaves the value unchanged and sets `Err`.
- `DispValue` shows A in ENTER_A, B in ENTER_B, and the result in SHOW. It holds its value during EXEC.
- `OperandA`, `OperandB` and `OpCode` are stable from the `Start` pulse until `Done`.

## Timing
- Key accept: `KeyRdy`=1 in cycle N with the guard armed and state ≠ EXEC.
  - Key fields are sampled at the end of cycle N.
  - `KeyRd`=1 during N+1 only.
  - The key's effect on operands, `DispValue` and state is visible in N+1.
- Guard: after each `KeyRd`, no new key is accepted until `KeyRdy` has been observed 0 for at least one cycle. This prevents a held key from being consumed twice.
- `Start` is asserted in the same cycle as the `KeyRd` for the equals key. The state reads EXEC from that cycle.
- `Done` in cycle M: state is SHOW and `DispValue`=`Result` in M+1. A key with `KeyRdy`=1 is accepted in M+1 at the earliest.
- `Done` outside EXEC is ignored.
- `Reset`=0 mid-operation: in the next cycle all outputs are 0 and the state is ENTER_A. A `Start` pulse in flight is not reissued.

## Structure
- Shared `calc_pkg` holds:
  - `op_t` enum for the `Operator` codes.
  - `state_t` enum for the FSM states.
  - `MAXMAG_DEFAULT` constant.
  - ×10 constant.
- Sub-module `operand_accum`: combinational. Takes the current signed value and a digit; returns the appended value and an overflow flag. It is instantiated once, with its input muxed between A and B.

## Test plan
- Keys 1,2,ADD,3,= → `Start` pulse with A=12, B=3, `OpCode`=1. ALU `Done` with `Result`=15 → `DispValue`=15, state SHOW.
- Keys 3,2,7,6,7,8 → A=32767 after five digits. The sixth digit sets `Err`=1 and A stays 32767. CLR → A=0, `Err`=0.
- Keys 5,NEG,MUL,SUB,4,= → A=−5, B=4, `OpCode`=2 (SUB replaced MUL).
- `KeyRdy` held high for 20 cycles → exactly one `KeyRd` pulse. Release, then press again → a second pulse.
- `KeyRdy` raised during EXEC → no `KeyRd`. After `Done` (`Result`=7) with an ADD key pending → ADD accepted, A=7, state ENTER_B.
- `Reset`=0 during ENTER_B with A=9 → the next cycle has A=B=0, `DispValue`=0, `KeyRd`=`Start`=0, state ENTER_A.
